// File: rtl/number_rom_pkg.sv
// Shared constants for the number ROM and its clients (arbiter, ROM
// instances, digit renderers), plus the requester-ID width helper.
package number_rom_pkg;

  localparam int NUMBER_ROM_ADDR_WIDTH = 10;
  localparam int NUMBER_ROM_DATA_WIDTH = 12;
  localparam int NUMBER_ROM_SIZE       = 1000;

  // Width of an index able to name n requesters, never less than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/number_rom_arbiter_rr_picker.sv
// rr_picker: combinational round-robin picker.
// Scans req starting one past 'last' (modulo NUM_REQ) and selects the first
// asserted bit.
//   req       in  NUM_REQ  request vector
//   last      in  ID_W     index granted most recently
//   grant     out NUM_REQ  one-hot grant (all zero when no request)
//   grant_idx out ID_W     index of the granted requester
//   any       out 1        some request is asserted
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = ID_W'((int'(last) + off) % NUM_REQ);
      if (!any && req[idx]) begin
        any         = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/number_rom_arbiter.sv
// number_rom_arbiter: round-robin sharing of the single-port, 1-cycle-latency
// number ROM between NUM_REQ pixel-fetch requesters.
//   clk       in  1                   clock, rising edge
//   reset     in  1                   asynchronous active-high reset
//   req_valid in  NUM_REQ             per-requester request
//   req_addr  in  NUM_REQ*ADDR_WIDTH  flattened request addresses
//   req_ready out NUM_REQ             one-hot combinational grant
//   rom_addr  out ADDR_WIDTH          registered ROM address
//   rom_data  in  DATA_WIDTH          ROM read data (one cycle after rom_addr)
//   rsp_valid out 1                   response strobe
//   rsp_id    out ID_W                requester index of the response
//   rsp_data  out DATA_WIDTH          ROM word, 0 on error
//   rsp_err   out 1                   request address was out of range
module number_rom_arbiter
  import number_rom_pkg::*;
#(
  parameter int  NUM_REQ    = 3,
  parameter int  ADDR_WIDTH = NUMBER_ROM_ADDR_WIDTH,
  parameter int  DATA_WIDTH = NUMBER_ROM_DATA_WIDTH,
  parameter int  ROM_SIZE   = NUMBER_ROM_SIZE,
  localparam int ID_W       = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]         rom_data,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err
);

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) >= 32'(ROM_SIZE);
  endfunction

  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_idx;
  logic [ID_W-1:0]       last_grant;
  logic                  any;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  range_err;

  logic                  vld_p1, err_p1;
  logic [ID_W-1:0]       id_p1;
  logic                  vld_p2, err_p2;
  logic [ID_W-1:0]       id_p2;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req       (req_valid),
    .last      (last_grant),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // The grant only ever names a valid requester, so any grant is an accept.
  assign req_ready = reset ? '0 : grant;
  assign accept    = any & ~reset;

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign range_err = out_of_range(sel_addr);

  // Stage 1: accept edge, address onto the ROM bus
  // Stage 2: ROM word registered, tags follow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      rom_addr   <= '0;
      vld_p1     <= 1'b0;
      id_p1      <= '0;
      err_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      id_p2      <= '0;
      err_p2     <= 1'b0;
    end else begin
      vld_p1 <= accept;
      err_p1 <= accept & range_err;
      if (accept) begin
        last_grant <= grant_idx;
        id_p1      <= grant_idx;
        // Out-of-range reads are parked on address 0; the data is discarded.
        rom_addr   <= range_err ? '0 : sel_addr;
      end
      vld_p2 <= vld_p1;
      id_p2  <= id_p1;
      err_p2 <= err_p1;
    end
  end

  // Response: ROM data is qualified by the stage-2 valid so idle cycles read 0.
  assign rsp_valid = vld_p2;
  assign rsp_id    = id_p2;
  assign rsp_err   = err_p2;
  assign rsp_data  = (vld_p2 && !err_p2) ? rom_data : '0;

endmodule

// File: tb/tb_number_rom_arbiter.sv
module tb_number_rom_arbiter;

  localparam int N  = 3;
  localparam int AW = 10;
  localparam int DW = 12;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data = '0;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;

  number_rom_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // ROM model: word[a] = a ^ 12'hA5A, one-cycle read latency.
  always @(posedge clk) rom_data <= {2'b00, rom_addr} ^ 12'hA5A;

  typedef struct {
    int          due;
    int          id;
    logic [11:0] data;
    logic        err;
  } rsp_t;

  rsp_t        q[$];
  int          ptr = N - 1;
  int          cyc = 0;
  int          wait_cnt [N];
  int          checks = 0;
  int          failures = 0;
  logic [N-1:0] snap_ready;
  logic        snap_valid, snap_err;
  logic [IW-1:0] snap_id;
  logic [DW-1:0] snap_data;
  logic        rv [N];
  logic [AW-1:0] ra [N];
  int          order [6];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int oh2idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic flush_model();
    q.delete();
    ptr = N - 1;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = rv[i];
      req_addr[i*AW +: AW] = ra[i];
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model, return
  // 1 time unit after the next rising edge.
  task automatic step();
    int          exp_idx;
    int          act_idx;
    logic [N-1:0] exp_ready;
    logic [AW-1:0] a;
    rsp_t        e;
    @(negedge clk);
    snap_ready = req_ready;
    snap_valid = rsp_valid;
    snap_id    = rsp_id;
    snap_data  = rsp_data;
    snap_err   = rsp_err;
    if (reset) flush_model();
    exp_idx = -1;
    if (!reset) begin
      for (int off = 1; off <= N; off++) begin
        int i = (ptr + off) % N;
        if (exp_idx < 0 && req_valid[i]) exp_idx = i;
      end
    end
    exp_ready = '0;
    if (exp_idx >= 0) exp_ready[exp_idx] = 1'b1;
    cmp("req_ready", 32'(req_ready), 32'(exp_ready));
    cmp("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      cmp("rsp_valid", 32'(rsp_valid), 32'd1);
      cmp("rsp_id", 32'(rsp_id), 32'(e.id));
      cmp("rsp_err", 32'(rsp_err), 32'(e.err));
      cmp("rsp_data", 32'(rsp_data), 32'(e.data));
    end else begin
      cmp("rsp_idle", 32'(rsp_valid), 32'd0);
      if (reset) begin
        cmp("rst_rsp_err", 32'(rsp_err), 32'd0);
        cmp("rst_rsp_data", 32'(rsp_data), 32'd0);
      end
    end
    if (exp_idx >= 0) begin
      a = req_addr[exp_idx*AW +: AW];
      e.due  = cyc + 2;
      e.id   = exp_idx;
      e.err  = (a >= 10'd1000);
      e.data = e.err ? 12'h000 : ({2'b00, a} ^ 12'hA5A);
      q.push_back(e);
      ptr = exp_idx;
    end
    // Fairness, measured on the DUT's own grants.
    act_idx = reset ? -1 : oh2idx(req_ready & req_valid);
    for (int j = 0; j < N; j++) begin
      if (!req_valid[j] || j == act_idx) wait_cnt[j] = 0;
      else if (act_idx >= 0) begin
        wait_cnt[j]++;
        if (wait_cnt[j] > N - 1) cmp("fair_wait", 32'(wait_cnt[j]), 32'(N - 1));
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic v);
    for (int i = 0; i < N; i++) rv[i] = v;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin rv[i] = 1'b1; ra[i] = AW'(i); wait_cnt[i] = 0; end
    drive();
    // Reset state, with requests asserted to show req_ready stays low.
    step();
    step();
    cmp("rst_rom_addr", 32'(rom_addr), 32'd0);
    cmp("rst_rsp_id", 32'(rsp_id), 32'd0);
    cmp("rst_rsp_data", 32'(rsp_data), 32'd0);
    cmp("rst_req_ready", 32'(snap_ready), 32'd0);
    set_all(1'b0);
    drive();
    reset = 1'b0;

    // Single request: req 1, addr 37.
    rv[1] = 1'b1; ra[1] = 10'd37; drive();
    step();
    cmp("single_ready", 32'(snap_ready), 32'h2);
    rv[1] = 1'b0; drive();
    step();
    step();
    cmp("single_valid", 32'(snap_valid), 32'd1);
    cmp("single_id", 32'(snap_id), 32'd1);
    cmp("single_data", 32'(snap_data), 32'hA7F);
    cmp("single_err", 32'(snap_err), 32'd0);

    // Rotation from a fresh pointer.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin rv[i] = 1'b1; ra[i] = AW'(200 + i); end
    drive();
    for (int k = 0; k < 6; k++) begin
      step();
      order[k] = oh2idx(snap_ready);
    end
    for (int k = 0; k < 6; k++) cmp("rot_order", 32'(order[k]), 32'(k % 3));
    set_all(1'b0); drive();
    repeat (3) step();

    // Pointer held across idle cycles (pointer is 2 here).
    rv[2] = 1'b1; ra[2] = 10'd500; drive();
    step();
    cmp("hold_first", 32'(snap_ready), 32'h4);
    rv[2] = 1'b0; drive();
    repeat (3) step();
    rv[0] = 1'b1; ra[0] = 10'd7; rv[2] = 1'b1; ra[2] = 10'd8; drive();
    step();
    cmp("hold_wrap", 32'(snap_ready), 32'h1);
    rv[0] = 1'b0; drive();
    step();
    cmp("hold_second", 32'(snap_ready), 32'h4);
    rv[2] = 1'b0; drive();
    repeat (3) step();

    // Address range boundaries on requester 0.
    rv[0] = 1'b1; ra[0] = 10'd1000; drive();
    step();
    cmp("oor_rom_addr_1000", 32'(rom_addr), 32'd0);
    ra[0] = 10'd1023; drive();
    step();
    cmp("oor_rom_addr_1023", 32'(rom_addr), 32'd0);
    ra[0] = 10'd999; drive();
    step();
    cmp("oor_rom_addr_999", 32'(rom_addr), 32'd999);
    cmp("oor_err_1000", 32'(snap_err), 32'd1);
    cmp("oor_data_1000", 32'(snap_data), 32'd0);
    rv[0] = 1'b0; drive();
    step();
    cmp("oor_err_1023", 32'(snap_err), 32'd1);
    cmp("oor_data_1023", 32'(snap_data), 32'd0);
    step();
    cmp("oor_err_999", 32'(snap_err), 32'd0);
    cmp("oor_data_999", 32'(snap_data), 32'h9BD);
    repeat (2) step();

    // Reset mid-flight: accepts in two cycles, async pulse in the third.
    rv[0] = 1'b1; ra[0] = 10'd5; rv[1] = 1'b1; ra[1] = 10'd6; drive();
    step();
    step();
    cmp("mid_rsp_before", 32'(rsp_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    cmp("mid_rsp_drop", 32'(rsp_valid), 32'd0);
    cmp("mid_ready_low", 32'(req_ready), 32'd0);
    cmp("mid_rom_addr", 32'(rom_addr), 32'd0);
    flush_model();
    #1 reset = 1'b0;
    step();
    cmp("mid_after_first", 32'(snap_ready), 32'h1);
    rv[0] = 1'b0; drive();
    step();
    cmp("mid_after_second", 32'(snap_ready), 32'h2);
    rv[1] = 1'b0; drive();
    repeat (3) step();

    // Random load with held requests.
    set_all(1'b0);
    snap_ready = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rv[i] && snap_ready[i]) rv[i] = 1'b0;
        if (!rv[i] && $urandom_range(1, 0) == 1) begin
          rv[i] = 1'b1;
          ra[i] = AW'($urandom_range(1023, 0));
        end
      end
      drive();
      step();
    end
    set_all(1'b0); drive();
    repeat (4) step();
    cmp("drain_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
